fetch_unit: RTL and testbench

//  Instruction fetch stage of the accumulator CPU: owns the program counter (PC) and instruction register (IR).

---
 rtl/cpu_pkg.sv | 14 +
 rtl/program_counter.sv | 22 ++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, fetch-state and width definitions for the accumulator CPU
package cpu_pkg;
   localparam int DATA_WIDTH        = 11;
   localparam int INSTRUCTION_WIDTH = 15;
   localparam int WORD_WIDTH        = INSTRUCTION_WIDTH + 1;
   localparam int OPCODE_WIDTH      = INSTRUCTION_WIDTH - DATA_WIDTH + 1;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI,
      BEQ, BNE, BGT, BGE, BLT, BLE, JMP
   } opcode_t;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} fetch_state_t;
endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with clear, branch-target load and increment (wraps modulo 2**W)
module program_counter #(
   parameter int W = 11
) (
   input  logic         clock_in,
   input  logic         reset_in,
   input  logic         clr_in,
   input  logic         ld_in,
   input  logic         inc_in,
   input  logic [W-1:0] target_in,
   output logic [W-1:0] pc_out
);
   logic [W-1:0] pc_d, pc_q;

   // clear beats load beats increment
   always_comb pc_d = clr_in ? '0 : ld_in ? target_in : inc_in ? pc_q + W'(1) : pc_q;

   // PC register, synchronous active-low reset
   always_ff @(posedge clock_in) pc_q <= !reset_in ? '0 : pc_d;

   assign pc_out = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning PC and IR, with req/ack instruction-memory port
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH        = 11,
   parameter int INSTRUCTION_WIDTH = 15
) (
   input  logic                                  clock_in,
   input  logic                                  reset_in,
   output logic                                  imem_req_out,
   output logic [DATA_WIDTH-1:0]                 imem_addr_out,
   input  logic                                  imem_ack_in,
   input  logic [INSTRUCTION_WIDTH:0]            imem_data_in,
   input  logic                                  pc_wr_in,
   input  logic                                  branch_in,
   input  logic                                  pc_reset_in,
   input  logic                                  ir_reset_in,
   output logic [INSTRUCTION_WIDTH-DATA_WIDTH:0] op_code_out,
   output logic [DATA_WIDTH-1:0]                 operand_out,
   output logic [DATA_WIDTH-1:0]                 pc_out,
   output logic                                  ir_valid_out,
   output logic                                  halted_out
);
   localparam int OW = INSTRUCTION_WIDTH - DATA_WIDTH + 1;

   fetch_state_t                 state_d, state_q;
   logic [INSTRUCTION_WIDTH:0]   ir_d, ir_q;
   logic                         ir_valid_d, ir_valid_q;
   logic                         pc_clr, pc_ld, pc_inc;

   program_counter #(.W(DATA_WIDTH)) u_pc (
      .clock_in  (clock_in),
      .reset_in  (reset_in),
      .clr_in    (pc_clr),
      .ld_in     (pc_ld),
      .inc_in    (pc_inc),
      .target_in (operand_out),
      .pc_out    (pc_out)
   );

   // next-state: normal fetch/exec flow, then decoder resets override it (dropping pc_wr and any ack)
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      pc_clr     = 1'b0;
      pc_ld      = 1'b0;
      pc_inc     = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (imem_ack_in) begin
            ir_d       = imem_data_in;
            ir_valid_d = 1'b1;
            state_d    = S_EXEC;
         end
         S_EXEC:  if (pc_wr_in) begin
            pc_ld      = branch_in;
            pc_inc     = !branch_in;
            ir_valid_d = 1'b0;
            state_d    = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
      if (pc_reset_in || ir_reset_in) begin
         pc_clr     = pc_reset_in;
         pc_ld      = 1'b0;
         pc_inc     = 1'b0;
         ir_d       = ir_reset_in ? '0 : ir_q;
         ir_valid_d = ir_reset_in ? 1'b0 : ir_valid_q;
         state_d    = (ir_reset_in || state_q != S_EXEC) ? S_FETCH : S_EXEC;
      end
   end

   // FSM and IR registers, synchronous active-low reset
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         state_q    <= S_IDLE;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign imem_req_out  = state_q == S_FETCH;
   assign imem_addr_out = pc_out;
   assign op_code_out   = ir_q[INSTRUCTION_WIDTH:DATA_WIDTH];
   assign operand_out   = ir_q[DATA_WIDTH-1:0];
   assign ir_valid_out  = ir_valid_q;
   assign halted_out    = ir_valid_q && op_code_out == OW'(HLT);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a delay-programmable memory model
module tb_fetch_unit;
   logic        clk, reset_in, imem_req, imem_ack, pc_wr, branch, pc_reset, ir_reset;
   logic        ir_valid, halted;
   logic [10:0] imem_addr, operand, pc;
   logic [15:0] imem_data;
   logic [4:0]  op_code;

   logic [15:0] mem [2048];
   int          ack_delay, wait_cnt, ack_cnt, n_chk, n_fail, a0;
   logic        stray;
   logic [10:0] last_addr;

   typedef struct {
      logic [10:0] addr;
      logic [15:0] word;
      logic        br;
      int          dly;
   } vec_t;
   vec_t tbl [5];

   fetch_unit dut (
      .clock_in     (clk),
      .reset_in     (reset_in),
      .imem_req_out (imem_req),
      .imem_addr_out(imem_addr),
      .imem_ack_in  (imem_ack),
      .imem_data_in (imem_data),
      .pc_wr_in     (pc_wr),
      .branch_in    (branch),
      .pc_reset_in  (pc_reset),
      .ir_reset_in  (ir_reset),
      .op_code_out  (op_code),
      .operand_out  (operand),
      .pc_out       (pc),
      .ir_valid_out (ir_valid),
      .halted_out   (halted)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // memory model: acks after ack_delay request cycles; stray drives ack while no request
   initial begin
      imem_ack  = 0;
      imem_data = 0;
      wait_cnt  = 0;
      ack_cnt   = 0;
      last_addr = 0;
      forever begin
         @(negedge clk);
         if (imem_req) begin
            if (wait_cnt >= ack_delay) begin
               imem_ack  = 1;
               imem_data = mem[imem_addr];
               last_addr = imem_addr;
               wait_cnt  = 0;
               ack_cnt++;
            end else begin
               imem_ack = 0;
               wait_cnt++;
            end
         end else begin
            imem_ack  = stray;
            imem_data = 16'hABCD;
            wait_cnt  = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fetch_wait(input string nm);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ir_valid) break;
      end
      chk({nm, "_valid"}, ir_valid, 1);
   endtask

   task automatic step(input logic b, input int d);
      ack_delay = d;
      pc_wr     = 1;
      branch    = b;
      @(negedge clk);
      pc_wr  = 0;
      branch = 0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      reset_in = 0; pc_wr = 0; branch = 0; pc_reset = 0; ir_reset = 0;
      stray = 0; ack_delay = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
      tbl[0] = '{11'h000, 16'h1812, 1'b0, 0};
      tbl[1] = '{11'h001, 16'h2020, 1'b0, 0};
      tbl[2] = '{11'h002, 16'h7005, 1'b1, 0};
      tbl[3] = '{11'h005, 16'h2807, 1'b0, 0};
      tbl[4] = '{11'h006, 16'h3003, 1'b0, 3};
      for (int i = 0; i < 5; i++) mem[tbl[i].addr] = tbl[i].word;
      mem[11'h007] = 16'h47FF;
      mem[11'h7FF] = 16'h0800;

      // reset held three cycles
      repeat (3) @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_pc", pc, 0);
      chk("rst_ir", {op_code, operand}, 0);
      chk("rst_valid", ir_valid, 0);
      chk("rst_halted", halted, 0);
      reset_in = 1;
      @(negedge clk);
      chk("post_rst_req", imem_req, 1);
      chk("post_rst_addr", imem_addr, 0);

      // straight-line program with a taken JMP
      for (int i = 0; i < 5; i++) begin
         fetch_wait($sformatf("v%0d", i));
         chk($sformatf("v%0d_addr", i), last_addr, tbl[i].addr);
         chk($sformatf("v%0d_pc", i), pc, tbl[i].addr);
         chk($sformatf("v%0d_op", i), op_code, tbl[i].word[15:11]);
         chk($sformatf("v%0d_operand", i), operand, tbl[i].word[10:0]);
         chk($sformatf("v%0d_halted", i), halted, 0);
         step(tbl[i].br, tbl[i].dly);
      end

      // slow memory: request held while waiting, one load per request
      a0 = ack_cnt;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("wait%0d_req", k), imem_req, 1);
         chk($sformatf("wait%0d_addr", k), imem_addr, 11'h007);
         chk($sformatf("wait%0d_valid", k), ir_valid, 0);
      end
      fetch_wait("slow");
      chk("slow_ir", {op_code, operand}, 16'h47FF);
      chk("slow_req_low", imem_req, 0);
      stray = 1;
      repeat (3) @(negedge clk);
      stray = 0;
      chk("stray_ir", {op_code, operand}, 16'h47FF);
      chk("stray_valid", ir_valid, 1);
      chk("one_load", ack_cnt - a0, 1);

      // branch to top of memory, then wrap to 0 and halt
      step(1, 0);
      fetch_wait("top");
      chk("top_pc", pc, 11'h7FF);
      chk("top_addr", last_addr, 11'h7FF);
      chk("top_ir", {op_code, operand}, 16'h0800);
      mem[0] = 16'h0000;
      step(0, 0);
      fetch_wait("wrap");
      chk("wrap_pc", pc, 0);
      chk("wrap_addr", last_addr, 0);
      chk("hlt_halted", halted, 1);
      repeat (5) @(negedge clk);
      chk("frozen_pc", pc, 0);
      chk("frozen_halted", halted, 1);
      chk("frozen_req", imem_req, 0);

      // pc_reset beats a simultaneous taken branch
      mem[1] = 16'h7010;
      step(0, 0);
      fetch_wait("jmp");
      chk("jmp_operand", operand, 11'h010);
      pc_reset = 1; pc_wr = 1; branch = 1;
      @(negedge clk);
      pc_reset = 0; pc_wr = 0; branch = 0;
      chk("pcrst_pc", pc, 0);

      // ir_reset coinciding with an ack discards it and refetches at the same PC
      step(0, 3);
      repeat (3) @(negedge clk);
      #1 ir_reset = 1;
      @(negedge clk);
      chk("irrst_valid", ir_valid, 0);
      chk("irrst_ir", {op_code, operand}, 0);
      chk("irrst_req", imem_req, 1);
      chk("irrst_pc", pc, 1);
      #1 ir_reset = 0;
      fetch_wait("refetch");
      chk("refetch_addr", last_addr, 1);
      chk("refetch_ir", {op_code, operand}, 16'h7010);

      // reset mid-fetch with an ack arriving on the following cycle
      mem[0] = 16'h1812;
      step(0, 3);
      #1 reset_in = 0; stray = 1;
      @(negedge clk);
      chk("midrst_req", imem_req, 0);
      chk("midrst_pc", pc, 0);
      chk("midrst_valid", ir_valid, 0);
      #1 reset_in = 1;
      @(negedge clk);
      chk("idle_ack_valid", ir_valid, 0);
      chk("idle_ack_ir", {op_code, operand}, 0);
      chk("restart_req", imem_req, 1);
      chk("restart_addr", imem_addr, 0);
      #1 stray = 0;
      fetch_wait("restart");
      chk("restart_ir", {op_code, operand}, 16'h1812);
      chk("restart_halted", halted, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
